fuzz_vector_harness: RTL and testbench
======================================

Name: fuzz_vector_harness

Overview:
Synthesizable stimulus player and response compactor for fuzz-generated DUTs, replacing hand-written constant-vector benches. Drives a parametrised-width DUT input bus from per-lane LFSRs and folds every-cycle DUT output into a MISR signature. Compares the signature against an expected value, so simulation and synthesized-netlist runs reduce to a single pass/fail.

Parameters:
IN_W, 52, width of the DUT input bus driven on stim
OUT_W, 127, width of the DUT output bus sampled on resp
SIG_W, 32, MISR signature width (fixed CRC-32 polynomial; only 32 supported)
DRAIN_CYCLES, 2, cycles of continued sampling after the last vector, to flush DUT pipelines
ZERO_FIRST, 1, 1: vector 0 is all-zero; 0: vector 0 comes from the LFSR

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous, active-high reset
start  in  1  pulse in IDLE or DONE begins a run; ignored while busy
num_vec  in  16  number of vectors in the run, including the zero vector
hold  in  4  extra cycles each vector is held (vector lasts hold+1 cycles)
seed  in  64  LFSR seed, latched at start
exp_sig  in  SIG_W  expected signature, compared on entry to DONE
stim  out  IN_W  DUT input bus
resp  in  OUT_W  DUT output bus
busy  out  1  high during ZERO/RUN/DRAIN
done  out  1  high in DONE, held until the next start or rst
sig  out  SIG_W  current MISR signature
pass  out  1  sig==exp_sig registered on entry to DONE

Behaviour:
- Reset values: stim=0, sig=0, busy=0, done=0, pass=0; state=IDLE; counters=0.
- States: IDLE, ZERO, RUN, DRAIN, DONE.
- start in IDLE/DONE at cycle t: latch num_vec, hold, seed; clear sig, done, pass. From t+1 busy=1.
  - If num_vec=0: go to DONE at t+1.
  - Else if ZERO_FIRST=1: go to ZERO.
  - Else: go to RUN.
- Lanes: K=ceil(IN_W/64) Galois right-shift LFSRs, mask 64'hD800000000000000 (x^64+x^63+x^61+x^60+1).
  - Lane i seed = seed ^ (i*64'h9E3779B97F4A7C15), mod 2^64. A resulting zero seed is forced to 64'h1.
  - stim = {lane K-1 .. lane 0} truncated to IN_W LSBs.
- ZERO: stim=0 for hold+1 cycles; counts as vector 0. Then RUN, or DRAIN if num_vec=1.
- RUN: stim shows the current lane states. All lanes advance once at each vector boundary (after hold+1 cycles). The first RUN vector is the seed states. RUN ends after vector num_vec-1, then goes to DRAIN.
- DRAIN: stim holds the last vector for DRAIN_CYCLES cycles. DRAIN_CYCLES=0 skips straight to DONE.
- MISR updates every cycle in ZERO/RUN/DRAIN, using resp as sampled on that edge:
  - fold = XOR of resp split into 32-bit chunks, top chunk zero-padded.
  - sig_next = {sig[30:0],1'b0} ^ (sig[31] ? 32'h04C11DB7 : 0) ^ fold.
- Entry to DONE: busy=0, done=1, pass=(sig_final==exp_sig). sig and stim hold until the next start.
- start while busy: ignored. start and rst in the same cycle: rst wins.
- rst mid-run: all outputs and state return to reset values on the next edge.
- Total busy cycles = num_vec*(hold+1)+DRAIN_CYCLES.

Decomposition:
- Package fuzz_harness_pkg:
  - LFSR_MASK, LANE_GOLDEN, MISR_POLY constants
  - state enum
  - fold function
- Sub-module fuzz_lfsr64, instantiated K times:
  - Ports: clk, rst, load, seed_in, adv, state.
  - Contains the zero-seed guard.

Test Plan:
- rst asserted 2 cycles, then idle 5 cycles -> stim=0, sig=0, busy=0, done=0, pass=0 throughout.
- num_vec=1, hold=0, ZERO_FIRST=1, DRAIN_CYCLES=2, resp=0, exp_sig=0, start at cycle 0 -> busy cycles 1-3, done=1 from cycle 4, sig=0, pass=1.
- DRAIN_CYCLES=0, num_vec=1, hold=0, resp=127'h1 -> sig=32'h1. Same with num_vec=2 -> sig=32'h3.
- IN_W=64, ZERO_FIRST=0, seed=64'h1, num_vec=2, hold=0 -> stim=64'h1, then 64'hD800000000000000. seed=0 -> first stim=64'h1.
- num_vec=3, hold=3, DRAIN_CYCLES=2 -> stim changes every 4 cycles, busy exactly 14 cycles. A start pulse at busy cycle 5 is ignored.
- rst at busy cycle 6 of a 10-vector run -> next edge: busy=0, stim=0, sig=0. A new start then runs cleanly to done with pass=1 against the golden signature.

Source files
------------

// File: rtl/fuzz_harness_pkg.sv
// rtl/fuzz_harness_pkg.sv - shared constants, state codes and helpers for the fuzz vector harness
package fuzz_harness_pkg;

  localparam logic [63:0] LFSR_MASK   = 64'hD800000000000000;
  localparam logic [63:0] LANE_GOLDEN = 64'h9E3779B97F4A7C15;
  localparam logic [31:0] MISR_POLY   = 32'h04C11DB7;
  localparam int          FOLD_MAX_W  = 1024;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ZERO  = 3'd1;
  localparam state_t ST_RUN   = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // Response buses narrower than FOLD_MAX_W are zero-extended, so padding chunks fold in as zero.
  function automatic logic [31:0] fold(input logic [FOLD_MAX_W-1:0] v);
    logic [31:0] f;
    f = '0;
    for (int c = 0; c < FOLD_MAX_W / 32; c++) begin
      f = f ^ v[c*32 +: 32];
    end
    return f;
  endfunction

  function automatic logic [63:0] lane_seed(input logic [63:0] seed, input int unsigned idx);
    return seed ^ (64'(idx) * LANE_GOLDEN);
  endfunction

endpackage

// File: rtl/fuzz_lfsr64.sv
// rtl/fuzz_lfsr64.sv - one 64-bit Galois right-shift LFSR lane with zero-seed guard
module fuzz_lfsr64
  import fuzz_harness_pkg::*;
#(
  parameter int OUT_BITS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [63:0]         seed_in,
  input  logic                adv,
  output logic [OUT_BITS-1:0] state
);

  logic [63:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed_in == 64'h0) ? 64'h1 : seed_in;
    end else if (adv) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? LFSR_MASK : 64'h0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= '0;
    else     state_q <= state_d;
  end

  assign state = state_q[OUT_BITS-1:0];

endmodule

// File: rtl/fuzz_vector_harness.sv
// rtl/fuzz_vector_harness.sv - LFSR stimulus player and MISR response compactor with pass/fail
module fuzz_vector_harness
  import fuzz_harness_pkg::*;
#(
  parameter int IN_W         = 52,
  parameter int OUT_W        = 127,
  parameter int SIG_W        = 32,
  parameter int DRAIN_CYCLES = 2,
  parameter int ZERO_FIRST   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      num_vec,
  input  logic [3:0]       hold,
  input  logic [63:0]      seed,
  input  logic [SIG_W-1:0] exp_sig,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig,
  output logic             pass
);

  localparam int K = (IN_W + 63) / 64;

  state_t           state_q, state_d;
  logic [15:0]      num_vec_q, num_vec_d;
  logic [15:0]      vec_cnt_q, vec_cnt_d;
  logic [15:0]      drain_cnt_q, drain_cnt_d;
  logic [3:0]       hold_q, hold_d;
  logic [3:0]       hold_cnt_q, hold_cnt_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             show_q, show_d;

  logic             load, adv, busy_int, last_beat, last_vec, drain_last;
  logic [IN_W-1:0]  lanes;
  logic [SIG_W-1:0] sig_next;
  state_t           after_vecs;

  for (genvar g = 0; g < K; g++) begin : g_lane
    localparam int LW = (IN_W - 64*g > 64) ? 64 : IN_W - 64*g;
    fuzz_lfsr64 #(.OUT_BITS(LW)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .seed_in (lane_seed(seed, g)),
      .adv     (adv),
      .state   (lanes[g*64 +: LW])
    );
  end

  assign busy_int   = (state_q == ST_ZERO) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign last_beat  = (hold_cnt_q == hold_q);
  assign last_vec   = (vec_cnt_q == num_vec_q - 16'd1);
  assign drain_last = (drain_cnt_q == 16'(DRAIN_CYCLES - 1));
  assign after_vecs = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
  assign sig_next   = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? MISR_POLY : 32'h0)
                    ^ fold(FOLD_MAX_W'(resp));

  always_comb begin
    state_d     = state_q;
    num_vec_d   = num_vec_q;
    vec_cnt_d   = vec_cnt_q;
    drain_cnt_d = drain_cnt_q;
    hold_d      = hold_q;
    hold_cnt_d  = hold_cnt_q;
    sig_d       = busy_int ? sig_next : sig_q;
    done_d      = done_q;
    pass_d      = pass_q;
    show_d      = show_q;
    load        = 1'b0;
    adv         = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          num_vec_d   = num_vec;
          hold_d      = hold;
          load        = 1'b1;
          sig_d       = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          show_d      = 1'b0;
          vec_cnt_d   = '0;
          hold_cnt_d  = '0;
          drain_cnt_d = '0;
          if (num_vec == 16'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (exp_sig == '0);
          end else if (ZERO_FIRST != 0) begin
            state_d = ST_ZERO;
          end else begin
            state_d = ST_RUN;
            show_d  = 1'b1;
          end
        end
      end
      ST_ZERO: begin
        if (last_beat) begin
          hold_cnt_d = '0;
          vec_cnt_d  = 16'd1;
          if (num_vec_q == 16'd1) begin
            state_d = after_vecs;
          end else begin
            state_d = ST_RUN;
            show_d  = 1'b1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      ST_RUN: begin
        if (last_beat) begin
          hold_cnt_d = '0;
          if (last_vec) begin
            state_d = after_vecs;
          end else begin
            vec_cnt_d = vec_cnt_q + 16'd1;
            adv       = 1'b1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      ST_DRAIN: begin
        if (drain_last) state_d = ST_DONE;
        else            drain_cnt_d = drain_cnt_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Verdict uses the signature including this cycle's final fold.
    if (busy_int && (state_d == ST_DONE)) begin
      done_d = 1'b1;
      pass_d = (sig_d == exp_sig);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      num_vec_q   <= '0;
      vec_cnt_q   <= '0;
      drain_cnt_q <= '0;
      hold_q      <= '0;
      hold_cnt_q  <= '0;
      sig_q       <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      show_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_vec_q   <= num_vec_d;
      vec_cnt_q   <= vec_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      hold_q      <= hold_d;
      hold_cnt_q  <= hold_cnt_d;
      sig_q       <= sig_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      show_q      <= show_d;
    end
  end

  assign stim = show_q ? lanes : '0;
  assign busy = busy_int;
  assign done = done_q;
  assign sig  = sig_q;
  assign pass = pass_q;

endmodule

// File: tb/tb_fuzz_vector_harness.sv
// tb/tb_fuzz_vector_harness.sv - randomized scoreboard bench for fuzz_vector_harness (two parameterisations)
module tb_fuzz_vector_harness;

  typedef struct {
    logic [31:0] sig;
    logic        pass;
    int          cycles;
  } res_t;

  logic         clk, rst, start_a, start_b;
  logic [15:0]  num_vec;
  logic [3:0]   hold;
  logic [63:0]  seed;
  logic [31:0]  exp_sig;
  logic [126:0] resp;
  logic [51:0]  stim_a;
  logic [63:0]  stim_b;
  logic         busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [31:0]  sig_a, sig_b;

  int           checks, errors;
  logic [63:0]  exp_stim_q[$];
  res_t         exp_res_q[$];

  fuzz_vector_harness u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .num_vec(num_vec), .hold(hold), .seed(seed),
    .exp_sig(exp_sig), .stim(stim_a), .resp(resp), .busy(busy_a), .done(done_a),
    .sig(sig_a), .pass(pass_a)
  );

  fuzz_vector_harness #(.IN_W(64), .OUT_W(127), .SIG_W(32), .DRAIN_CYCLES(0), .ZERO_FIRST(0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .num_vec(num_vec), .hold(hold), .seed(seed),
    .exp_sig(exp_sig), .stim(stim_b), .resp(resp), .busy(busy_b), .done(done_b),
    .sig(sig_b), .pass(pass_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? 64'hD800000000000000 : 64'h0);
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [126:0] r);
    logic [31:0] f;
    f = 32'h0;
    for (int c = 0; c < 4; c++) f = f ^ 32'(r >> (32 * c));
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  // Monitor: pops one expected stim per busy cycle and one verdict per rising done.
  initial begin
    logic pa, pb;
    int   busy_cnt;
    logic [63:0] e;
    res_t r;
    pa = 1'b0; pb = 1'b0; busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (busy_a || busy_b) begin
          busy_cnt++;
          if (exp_stim_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL stim_extra: busy cycle %0d has no expected vector", busy_cnt);
          end else begin
            e = exp_stim_q.pop_front();
            check("stim", busy_b ? stim_b : {12'h0, stim_a}, e);
          end
        end
        if ((done_a && !pa) || (done_b && !pb)) begin
          if (exp_res_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_extra: done rose with no run outstanding");
          end else begin
            r = exp_res_q.pop_front();
            check("sig",    done_b && !pb ? sig_b : sig_a, r.sig);
            check("pass",   done_b && !pb ? pass_b : pass_a, r.pass);
            check("busy_len", busy_cnt, r.cycles);
          end
          busy_cnt = 0;
        end
      end
      pa = done_a; pb = done_b;
    end
  end

  task automatic run(input bit use_b, input int nv, input int h, input logic [63:0] sd,
                     input int resp_mode, input bit good, input int pulse_at, input int rst_at);
    int in_w, dr, cycles, k;
    bit zf;
    logic [63:0] lane, m;
    logic [63:0] vecs[$];
    logic [126:0] rq[$];
    logic [126:0] rv;
    logic [31:0] s;
    res_t r;
    in_w = use_b ? 64 : 52;
    zf   = !use_b;
    dr   = use_b ? 0 : 2;
    m    = (in_w == 64) ? 64'hFFFFFFFFFFFFFFFF : ((64'h1 << in_w) - 64'h1);
    lane = (sd == 64'h0) ? 64'h1 : sd;
    for (int v = 0; v < nv; v++) begin
      if (zf && v == 0) vecs.push_back(64'h0);
      else begin
        vecs.push_back(lane & m);
        lane = lfsr_next(lane);
      end
    end
    s = 32'h0; cycles = 0;
    for (int v = 0; v < nv + ((nv > 0) ? dr : 0); v++) begin
      for (int b = 0; b < ((v < nv) ? h + 1 : 1); b++) begin
        case (resp_mode)
          1:       rv = '0;
          2:       rv = 127'h1;
          default: rv = 127'({$urandom, $urandom, $urandom, $urandom});
        endcase
        rq.push_back(rv);
        exp_stim_q.push_back(vecs[(v < nv) ? v : nv - 1]);
        s = misr_step(s, rv);
        cycles++;
      end
    end
    r.sig = s; r.pass = good; r.cycles = cycles;
    exp_res_q.push_back(r);

    num_vec = 16'(nv); hold = 4'(h); seed = sd;
    exp_sig = good ? s : s ^ 32'h1;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    num_vec = 16'($urandom); hold = 4'($urandom); seed = {$urandom, $urandom};
    for (int j = 0; j < cycles; j++) begin
      resp = rq[j];
      if (j == pulse_at) begin
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
      end
      if (j == rst_at) rst = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      if (j == rst_at) begin
        rst = 1'b0;
        check("rst_busy", use_b ? busy_b : busy_a, 1'b0);
        check("rst_stim", use_b ? stim_b : {12'h0, stim_a}, 64'h0);
        check("rst_sig",  use_b ? sig_b : sig_a, 32'h0);
        check("rst_done", use_b ? done_b : done_a, 1'b0);
        exp_stim_q.delete();
        exp_res_q.delete();
        return;
      end
    end
    k = 0;
    while (!(use_b ? done_b : done_a) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_seen", use_b ? done_b : done_a, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    num_vec = '0; hold = '0; seed = '0; exp_sig = '0; resp = '0;
    repeat (7) begin
      @(posedge clk); #1;
      if (checks >= 4) rst = 1'b0;
      check("reset_a", {busy_a, done_a, pass_a, sig_a, stim_a}, '0);
      check("reset_b", {busy_b, done_b, pass_b, sig_b, stim_b}, '0);
    end
    rst = 1'b0;

    run(1'b0, 0, 0, {$urandom, $urandom}, 0, 1'b1, -1, -1);
    run(1'b1, 0, 0, {$urandom, $urandom}, 0, 1'b0, -1, -1);

    run(1'b0, 1, 0, {$urandom, $urandom}, 1, 1'b1, -1, -1);
    check("zero_run_sig", sig_a, 32'h0);
    run(1'b1, 1, 0, {$urandom, $urandom}, 2, 1'b1, -1, -1);
    check("one_vec_sig", sig_b, 32'h1);
    run(1'b1, 2, 0, {$urandom, $urandom}, 2, 1'b1, -1, -1);
    check("two_vec_sig", sig_b, 32'h3);
    run(1'b1, 2, 0, 64'h1, 0, 1'b1, -1, -1);
    check("lfsr_step_hold", stim_b, 64'hD800000000000000);
    run(1'b1, 1, 0, 64'h0, 0, 1'b1, -1, -1);
    check("zero_seed_guard", stim_b, 64'h1);

    run(1'b0, 3, 3, {$urandom, $urandom}, 0, 1'b1, 5, -1);
    run(1'b0, 3, 3, {$urandom, $urandom}, 0, 1'b0, -1, -1);
    run(1'b0, 10, 1, 64'h0123456789ABCDEF, 0, 1'b1, -1, 5);
    run(1'b0, 10, 1, 64'h0123456789ABCDEF, 0, 1'b1, -1, -1);

    for (int i = 0; i < 12; i++) begin
      run(1'($urandom_range(0, 1)), $urandom_range(1, 12), $urandom_range(0, 3),
          {$urandom, $urandom}, 0, ($urandom_range(0, 3) != 0), -1, -1);
    end

    checks++;
    if (exp_stim_q.size() != 0 || exp_res_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d stim and %0d results never observed, expected 0",
               exp_stim_q.size(), exp_res_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
